// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_sequencer
// Description : Supervises an iCE40 PLL from the 12 MHz reference clock.
//               Pulses PLL RESETB, waits for lock with timeout and bounded
//               retries, qualifies lock stability before releasing the
//               downstream system reset, and restarts on any loss of lock.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer #(
   parameter int SYNC_STAGES   = 2,
   parameter int RESET_CYCLES  = 16,
   parameter int LOCK_TIMEOUT  = 1200,
   parameter int STABLE_CYCLES = 256,
   parameter int MAX_RETRIES   = 3,
   parameter int COUNT_WIDTH   = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   locked,
   output logic                   pll_resetb,
   output logic                   sys_reset,
   output logic                   ready,
   output logic                   fault,
   output logic [COUNT_WIDTH-1:0] lock_loss_count,
   output logic [2:0]             state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_HOLD      = 3'd1,
      S_WAIT_LOCK = 3'd2,
      S_STABILIZE = 3'd3,
      S_RUN       = 3'd4,
      S_FAULT     = 3'd5
   } state_t;

   // One shared timer covers the longest of the three timed phases.
   localparam int c_timer_max_a = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
   localparam int c_timer_max   = (c_timer_max_a > STABLE_CYCLES) ? c_timer_max_a : STABLE_CYCLES;
   localparam int c_timer_w     = (c_timer_max > 1) ? $clog2(c_timer_max) : 1;
   localparam int c_retry_w     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   localparam logic [c_timer_w-1:0]   c_timer_one   = c_timer_w'(1);
   localparam logic [c_timer_w-1:0]   c_hold_last   = c_timer_w'(RESET_CYCLES - 1);
   localparam logic [c_timer_w-1:0]   c_wait_last   = c_timer_w'(LOCK_TIMEOUT - 1);
   localparam logic [c_timer_w-1:0]   c_stable_last = c_timer_w'(STABLE_CYCLES - 1);
   localparam logic [c_retry_w-1:0]   c_retry_one   = c_retry_w'(1);
   localparam logic [c_retry_w-1:0]   c_retry_max   = c_retry_w'(MAX_RETRIES);
   localparam logic [COUNT_WIDTH-1:0] c_count_one   = COUNT_WIDTH'(1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_locked_s;

   state_t                 r_state;
   logic [c_timer_w-1:0]   r_timer;
   logic [c_retry_w-1:0]   r_retries;
   logic [COUNT_WIDTH-1:0] r_count;
   logic                   r_pll_resetb;
   logic                   r_sys_reset;
   logic                   r_ready;
   logic                   r_fault;

   state_t                 w_next_state;
   logic [c_timer_w-1:0]   w_next_timer;
   logic [c_retry_w-1:0]   w_next_retries;
   logic                   w_count_inc;

   // Shift the asynchronous lock indication through the synchroniser chain.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], locked};
      end
   end

   assign w_locked_s = r_sync[SYNC_STAGES-1];

   // Next-state, timer and retry decisions; enable low overrides every state.
   always_comb begin
      w_next_state   = r_state;
      w_next_timer   = r_timer;
      w_next_retries = r_retries;
      w_count_inc    = 1'b0;
      if (!enable) begin
         w_next_state   = S_IDLE;
         w_next_timer   = '0;
         w_next_retries = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_next_state   = S_HOLD;
               w_next_timer   = '0;
               w_next_retries = '0;
            end
            S_HOLD: begin
               if (r_timer == c_hold_last) begin
                  w_next_state = S_WAIT_LOCK;
                  w_next_timer = '0;
               end else begin
                  w_next_timer = r_timer + c_timer_one;
               end
            end
            S_WAIT_LOCK: begin
               // Lock is checked first so a lock arriving on the timeout cycle wins.
               if (w_locked_s) begin
                  w_next_state = S_STABILIZE;
                  w_next_timer = '0;
               end else if (r_timer == c_wait_last) begin
                  w_next_timer = '0;
                  if (r_retries == c_retry_max) begin
                     w_next_state = S_FAULT;
                  end else begin
                     w_next_state   = S_HOLD;
                     w_next_retries = r_retries + c_retry_one;
                  end
               end else begin
                  w_next_timer = r_timer + c_timer_one;
               end
            end
            S_STABILIZE: begin
               // A dropout restarts qualification without another PLL reset.
               if (!w_locked_s) begin
                  w_next_state = S_WAIT_LOCK;
                  w_next_timer = '0;
               end else if (r_timer == c_stable_last) begin
                  w_next_state = S_RUN;
                  w_next_timer = '0;
               end else begin
                  w_next_timer = r_timer + c_timer_one;
               end
            end
            S_RUN: begin
               if (!w_locked_s) begin
                  w_next_state   = S_HOLD;
                  w_next_timer   = '0;
                  w_next_retries = '0;
                  w_count_inc    = 1'b1;
               end
            end
            S_FAULT: begin
               w_next_state = S_FAULT;
            end
            default: begin
               w_next_state   = S_IDLE;
               w_next_timer   = '0;
               w_next_retries = '0;
            end
         endcase
      end
   end

   // Register state and decode outputs from the state being entered.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_timer      <= '0;
         r_retries    <= '0;
         r_count      <= '0;
         r_pll_resetb <= 1'b0;
         r_sys_reset  <= 1'b1;
         r_ready      <= 1'b0;
         r_fault      <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_timer      <= w_next_timer;
         r_retries    <= w_next_retries;
         r_pll_resetb <= (w_next_state == S_WAIT_LOCK) ||
                         (w_next_state == S_STABILIZE) ||
                         (w_next_state == S_RUN);
         r_sys_reset  <= (w_next_state != S_RUN);
         r_ready      <= (w_next_state == S_RUN);
         r_fault      <= (w_next_state == S_FAULT);
         if (w_count_inc && (r_count != {COUNT_WIDTH{1'b1}})) begin
            r_count <= r_count + c_count_one;
         end
      end
   end

   assign pll_resetb      = r_pll_resetb;
   assign sys_reset       = r_sys_reset;
   assign ready           = r_ready;
   assign fault           = r_fault;
   assign lock_loss_count = r_count;
   assign state           = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_sequencer
// Description : Directed self-checking bench for pll_lock_sequencer with
//               hand-computed cycle-exact expectations (COUNT_WIDTH = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_sequencer;

   localparam logic [31:0] c_idle  = 32'd0;
   localparam logic [31:0] c_hold  = 32'd1;
   localparam logic [31:0] c_wait  = 32'd2;
   localparam logic [31:0] c_stab  = 32'd3;
   localparam logic [31:0] c_run   = 32'd4;
   localparam logic [31:0] c_fault = 32'd5;

   logic       clock;
   logic       reset;
   logic       enable;
   logic       locked;
   logic       pll_resetb;
   logic       sys_reset;
   logic       ready;
   logic       fault;
   logic [1:0] lock_loss_count;
   logic [2:0] state;

   int checks   = 0;
   int failures = 0;

   pll_lock_sequencer #(
      .SYNC_STAGES  (2),
      .RESET_CYCLES (16),
      .LOCK_TIMEOUT (1200),
      .STABLE_CYCLES(256),
      .MAX_RETRIES  (3),
      .COUNT_WIDTH  (2)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .locked         (locked),
      .pll_resetb     (pll_resetb),
      .sys_reset      (sys_reset),
      .ready          (ready),
      .fault          (fault),
      .lock_loss_count(lock_loss_count),
      .state          (state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [31:0] st, input logic prb,
                                input logic srst, input logic rdy, input logic flt,
                                input logic [31:0] cnt);
      check({tag, ".state"},      32'(state),           st);
      check({tag, ".pll_resetb"}, 32'(pll_resetb),      32'(prb));
      check({tag, ".sys_reset"},  32'(sys_reset),       32'(srst));
      check({tag, ".ready"},      32'(ready),           32'(rdy));
      check({tag, ".fault"},      32'(fault),           32'(flt));
      check({tag, ".count"},      32'(lock_loss_count), cnt);
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      locked = 1'b0;
      tick(3);
      check_outputs("reset", c_idle, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      reset = 1'b0;
      tick(2);
      check("idle_disabled", 32'(state), c_idle);

      // Nominal bring-up: lock 50 cycles after RESETB rises.
      enable = 1'b1;
      tick(1);
      check_outputs("hold_entry", c_hold, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      tick(15);
      check_outputs("hold_last", c_hold, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      tick(1);
      check_outputs("wait_entry", c_wait, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      tick(50);
      locked = 1'b1;
      tick(2);
      check("sync_latency", 32'(state), c_wait);
      tick(1);
      check_outputs("stab_entry", c_stab, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      tick(255);
      check_outputs("stab_last", c_stab, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      tick(1);
      check_outputs("run_entry", c_run, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);

      // Loss of lock in RUN: HOLD after SYNC_STAGES+1 edges.
      locked = 1'b0;
      tick(2);
      check("loss_still_run", 32'(state), c_run);
      tick(1);
      check_outputs("loss_hold", c_hold, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1);
      locked = 1'b1;
      tick(16);
      check("rebring_wait", 32'(state), c_wait);
      tick(1);
      check("rebring_stab", 32'(state), c_stab);

      // Three-cycle lock glitch at stable-count 100.
      tick(100);
      check("glitch_pre", 32'(state), c_stab);
      locked = 1'b0;
      tick(3);
      check_outputs("glitch_wait", c_wait, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1);
      locked = 1'b1;
      tick(2);
      check_outputs("glitch_wait2", c_wait, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1);
      tick(1);
      check_outputs("glitch_restab", c_stab, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1);
      tick(255);
      check("glitch_full_requal", 32'(state), c_stab);
      tick(1);
      check_outputs("glitch_run", c_run, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1);

      // enable drops on the same cycle RUN sees lock loss: IDLE, no count.
      locked = 1'b0;
      tick(2);
      enable = 1'b0;
      tick(1);
      check_outputs("en_drop_idle", c_idle, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1);
      enable = 1'b1;
      locked = 1'b1;
      tick(1);
      check("reenable_hold", 32'(state), c_hold);
      tick(16);
      check("reenable_wait", 32'(state), c_wait);
      tick(1);
      check("reenable_stab", 32'(state), c_stab);
      tick(256);
      check_outputs("reenable_run", c_run, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1);

      // Lock losses 2..5 with a 2-bit counter: saturates at 3.
      for (int i = 2; i <= 5; i++) begin
         locked = 1'b0;
         tick(3);
         check_outputs("sat_loss", c_hold, 1'b0, 1'b1, 1'b0, 1'b0, (i > 3) ? 32'd3 : 32'(i));
         locked = 1'b1;
         tick(16);
         check("sat_wait", 32'(state), c_wait);
         tick(1);
         check("sat_stab", 32'(state), c_stab);
         tick(256);
         check("sat_run", 32'(state), c_run);
      end

      // Synchronous reset mid-STABILIZE.
      locked = 1'b0;
      tick(3);
      locked = 1'b1;
      tick(17);
      tick(50);
      check("pre_reset_stab", 32'(state), c_stab);
      reset  = 1'b1;
      locked = 1'b0;
      tick(1);
      check_outputs("mid_reset", c_idle, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      reset = 1'b0;
      tick(1);
      check("post_reset_hold", 32'(state), c_hold);

      // Lock never arrives: four attempts of 1200 WAIT_LOCK cycles, then FAULT.
      for (int n = 0; n < 4; n++) begin
         tick(16);
         check_outputs("to_wait", c_wait, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
         tick(1199);
         check("to_wait_last", 32'(state), c_wait);
         tick(1);
         check("to_expire", 32'(state), (n == 3) ? c_fault : c_hold);
      end
      check_outputs("fault", c_fault, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
      tick(20);
      check("fault_sticky", 32'(state), c_fault);
      enable = 1'b0;
      tick(1);
      check_outputs("fault_clear", c_idle, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      enable = 1'b1;
      tick(1);
      check("restart_hold", 32'(state), c_hold);

      // Lock arriving exactly in the timeout cycle wins over retry.
      tick(16);
      check("tl_wait", 32'(state), c_wait);
      tick(1197);
      locked = 1'b1;
      tick(2);
      check("tl_wait_last", 32'(state), c_wait);
      tick(1);
      check_outputs("tl_stab", c_stab, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Supervises the iCE40 PLL wrapper and drives its RESETB input. It issues the PLL reset and waits for lock with a timeout and bounded retries. It qualifies lock stability before releasing the system reset, and restarts the PLL on any loss of lock. It runs on the 12 MHz reference clock, which is always present, and never on the PLL output.

Parameters:
SYNC_STAGES, 2, synchroniser depth on the asynchronous locked input (>=2)
RESET_CYCLES, 16, cycles pll_resetb is held low per reset attempt (>=1)
LOCK_TIMEOUT, 1200, cycles allowed in WAIT_LOCK per attempt (100 us at 12 MHz)
STABLE_CYCLES, 256, consecutive synchronised-lock cycles needed before RUN
MAX_RETRIES, 3, extra reset attempts after the first timeout before FAULT
COUNT_WIDTH, 8, width of lock_loss_count

Ports:
clock  in  1  12 MHz reference clock; same net as the PLL reference input
reset  in  1  synchronous, active-high; all state returns to reset values
enable  in  1  1 = bring up and maintain PLL; 0 = hold PLL in reset, clear FAULT
locked  in  1  PLL LOCK output, asynchronous to clock
pll_resetb  out  1  to PLL RESETB; 0 = PLL held in reset
sys_reset  out  1  active-high reset for logic on the PLL output clock; consumers resynchronise it
ready  out  1  1 only in RUN
fault  out  1  1 only in FAULT
lock_loss_count  out  COUNT_WIDTH  saturating count of RUN->HOLD transitions
state  out  3  encoded FSM state: IDLE=0, HOLD=1, WAIT_LOCK=2, STABILIZE=3, RUN=4, FAULT=5

Behaviour:
- Reset values: pll_resetb=0, sys_reset=1, ready=0, fault=0, lock_loss_count=0, state=IDLE. Synchroniser flops, timer and retry count are cleared to 0.
- All outputs are registered and are decoded from the state being entered, so they change on the same edge as state.
- locked_s is locked after SYNC_STAGES flops. The FSM sees only locked_s, so its latency from the locked pin is SYNC_STAGES cycles.
- Priority: reset > enable==0 > state logic. When enable==0 in any state, the next state is IDLE.
- IDLE: pll_resetb=0, sys_reset=1. When enable==1, go to HOLD with timer=0 and retries=0.
- HOLD: pll_resetb=0, sys_reset=1. Stay exactly RESET_CYCLES cycles, then go to WAIT_LOCK with timer=0.
- WAIT_LOCK: pll_resetb=1, sys_reset=1. The timer increments each cycle.
  - If locked_s==1, go to STABILIZE with timer=0.
  - Otherwise, when timer==LOCK_TIMEOUT-1: if retries==MAX_RETRIES, go to FAULT; else retries+=1 and go to HOLD.
  - If locked_s rises in the timeout cycle, lock wins.
- STABILIZE: pll_resetb=1, sys_reset=1.
  - If locked_s==0, go to WAIT_LOCK with timer=0 and retries unchanged.
  - After STABLE_CYCLES consecutive cycles of locked_s==1, go to RUN.
- RUN: pll_resetb=1, sys_reset=0, ready=1.
  - If locked_s==0, go to HOLD next cycle: sys_reset=1 and ready=0 on that edge, lock_loss_count+=1 (saturating at all-ones), retries=0.
- FAULT: pll_resetb=0, sys_reset=1, fault=1. Sticky until enable==0 (to IDLE) or reset.
- If enable drops in the same cycle RUN sees lock loss, go to IDLE and do not increment lock_loss_count.
- Reset asserted mid-operation returns everything, including lock_loss_count, to reset values on the next edge.
- The timer is wide enough for max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).
- The retry counter is wide enough for MAX_RETRIES; MAX_RETRIES=0 means the first timeout goes straight to FAULT.
- Minimum enable-to-ready time with an immediately locking PLL: RESET_CYCLES + SYNC_STAGES + STABLE_CYCLES + 2 cycles.

Test Plan:
- Nominal bring-up: reset, enable=1; PLL model asserts locked 50 cycles after pll_resetb rises. Required: pll_resetb low for exactly 16 cycles, ready=1 and sys_reset=0 after a further 50+2+256 cycles plus FSM edges, lock_loss_count=0.
- Lock glitch in STABILIZE: locked drops for 3 cycles at stable-count 100. Required: return to WAIT_LOCK, then a full 256-cycle requalification; pll_resetb stays 1 throughout; no count change.
- Loss of lock in RUN: deassert locked. Required: SYNC_STAGES+1 cycles later sys_reset=1, ready=0, state=HOLD, lock_loss_count=1; bring-up then completes again.
- Timeout/fault: locked held 0. Required: 4 HOLD/WAIT_LOCK attempts, each WAIT_LOCK lasting 1200 cycles, then fault=1, pll_resetb=0. With enable=0 the next state is IDLE and fault=0; with enable=1 bring-up restarts.
- Saturation and reset: COUNT_WIDTH=2 with 5 RUN lock losses. Required: count sticks at 3. A synchronous reset pulse mid-STABILIZE gives all outputs their reset values on the next edge and count=0.
- Simultaneous events: enable=0 in the same cycle as RUN lock loss gives IDLE with count unchanged. Lock arriving in the timeout cycle gives STABILIZE, not HOLD.
